// File: rtl/fir_xifu_ex.sv
// ---------------------------------------------------------------------------
// fir_xifu_ex
//
// Execute stage of the FIR XIF coprocessor unit. It sits between the
// decode/issue stage and the writeback stage and holds a single in-flight
// offloaded instruction:
//   XFIRDOTP : op_c + lo(a)*lo(b) + hi(a)*hi(b), all halves signed 16-bit
//   XFIRLW   : issues an XIF memory read at op_a, result = op_a + ADDR_INC
//   XFIRSW   : issues an XIF memory write of op_b at op_a, result as above
// Finished instructions go to writeback through a registered ex2wb bundle
// that honours backpressure from wb_ready_i.
//
// Instruction encoding (id2ex_instr_i / ex2wb_instr_o, 3 bits):
//   3'd0 INSTR_INVALID, 3'd1 XFIRLW, 3'd2 XFIRSW, 3'd3 XFIRDOTP,
//   every other code is unsupported and is never accepted.
//
// Configuration macro:
//   FIR_XIFU_DOTP_SAT_EN  defined   -> dot-product saturates to 32-bit signed
//                         undefined -> dot-product wraps modulo 2^32
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   id2ex_*_i            instruction bundle from decode/issue (valid, instr,
//                        id, rd, rs1, op_a, op_b, op_c)
//   ready_o              EX can accept id2ex this cycle
//   xif_mem_valid_o      XIF memory request valid
//   xif_mem_ready_i      XIF memory request ready
//   xif_mem_req_*_o      XIF memory request fields (id, addr, we, be, size,
//                        wdata)
//   ex2wb_*_o            registered bundle to writeback (instr, id, rd, rs1,
//                        result)
//   wb_ready_i           writeback can accept a new ex2wb bundle
//   kill_i               per-id kill vector from the controller
// ---------------------------------------------------------------------------
module fir_xifu_ex #(
   parameter int unsigned X_ID_WIDTH = 4,
   parameter int unsigned ADDR_INC   = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,

   input  logic                       id2ex_valid_i,
   input  logic [2:0]                 id2ex_instr_i,
   input  logic [X_ID_WIDTH-1:0]      id2ex_id_i,
   input  logic [4:0]                 id2ex_rd_i,
   input  logic [4:0]                 id2ex_rs1_i,
   input  logic [31:0]                id2ex_op_a_i,
   input  logic [31:0]                id2ex_op_b_i,
   input  logic [31:0]                id2ex_op_c_i,
   output logic                       ready_o,

   output logic                       xif_mem_valid_o,
   input  logic                       xif_mem_ready_i,
   output logic [X_ID_WIDTH-1:0]      xif_mem_req_id_o,
   output logic [31:0]                xif_mem_req_addr_o,
   output logic                       xif_mem_req_we_o,
   output logic [3:0]                 xif_mem_req_be_o,
   output logic [2:0]                 xif_mem_req_size_o,
   output logic [31:0]                xif_mem_req_wdata_o,

   output logic [2:0]                 ex2wb_instr_o,
   output logic [X_ID_WIDTH-1:0]      ex2wb_id_o,
   output logic [4:0]                 ex2wb_rd_o,
   output logic [4:0]                 ex2wb_rs1_o,
   output logic [31:0]                ex2wb_result_o,
   input  logic                       wb_ready_i,

   input  logic [2**X_ID_WIDTH-1:0]   kill_i
);

   localparam logic [2:0] INSTR_INVALID = 3'd0;
   localparam logic [2:0] INSTR_LW      = 3'd1;
   localparam logic [2:0] INSTR_SW      = 3'd2;
   localparam logic [2:0] INSTR_DOTP    = 3'd3;

   // Stage register S
   logic                  sValid_q, sValid_d;
   logic [2:0]            sInstr_q, sInstr_d;
   logic [X_ID_WIDTH-1:0] sId_q, sId_d;
   logic [4:0]            sRd_q, sRd_d;
   logic [4:0]            sRs1_q, sRs1_d;
   logic [31:0]           sOpA_q, sOpA_d;
   logic [31:0]           sOpB_q, sOpB_d;
   logic [31:0]           sOpC_q, sOpC_d;
   logic                  memDone_q, memDone_d;

   // Writeback bundle register
   logic [2:0]            ex2wbInstr_q, ex2wbInstr_d;
   logic [X_ID_WIDTH-1:0] ex2wbId_q, ex2wbId_d;
   logic [4:0]            ex2wbRd_q, ex2wbRd_d;
   logic [4:0]            ex2wbRs1_q, ex2wbRs1_d;
   logic [31:0]           ex2wbResult_q, ex2wbResult_d;

   // Control
   logic                  instrSupported;
   logic                  sIsMem;
   logic                  sKilled;
   logic                  memValid;
   logic                  memHandshake;
   logic                  sDone;
   logic                  advance;
   logic                  ready;
   logic                  load;

   // Datapath
   logic signed [15:0]    aLo, aHi, bLo, bHi;
   logic signed [31:0]    prodLo, prodHi;
   logic [31:0]           dotpResult;
   logic [31:0]           memResult;
   logic [31:0]           result;

   // Handshake and flow control. A killed instruction gates its own memory
   // request low in the same cycle, so a coincident mem_ready can never
   // complete a transaction for it. Memory ops finish either on the live
   // handshake or on a handshake remembered from an earlier stalled cycle.
   always_comb begin
      instrSupported = (id2ex_instr_i == INSTR_LW) || (id2ex_instr_i == INSTR_SW) ||
                       (id2ex_instr_i == INSTR_DOTP);
      sIsMem         = (sInstr_q == INSTR_LW) || (sInstr_q == INSTR_SW);
      sKilled        = sValid_q & kill_i[sId_q];
      memValid       = sValid_q & sIsMem & ~memDone_q & ~sKilled;
      memHandshake   = memValid & xif_mem_ready_i;
      sDone          = sIsMem ? (memHandshake | memDone_q) : 1'b1;
      advance        = sValid_q & sDone & ~sKilled & wb_ready_i;
      ready          = ~sValid_q | (sDone & wb_ready_i) | sKilled;
      load           = id2ex_valid_i & instrSupported & ready;
   end

   // Packed 2x16 signed products. The low 32 bits of a 32x32 product of
   // sign-extended halves are the exact 16x16 signed product.
   always_comb begin
      aLo    = sOpA_q[15:0];
      aHi    = sOpA_q[31:16];
      bLo    = sOpB_q[15:0];
      bHi    = sOpB_q[31:16];
      prodLo = 32'(aLo) * 32'(bLo);
      prodHi = 32'(aHi) * 32'(bHi);
   end

`ifdef FIR_XIFU_DOTP_SAT_EN
   // Saturating build: the sum of three 32-bit signed terms fits in 34 bits;
   // it is representable in 32 bits exactly when bits [33:31] agree.
   logic signed [31:0] opCSigned;
   logic signed [33:0] dotpSum;

   always_comb begin
      opCSigned = sOpC_q;
      dotpSum   = 34'(opCSigned) + 34'(prodLo) + 34'(prodHi);
      if ((dotpSum[33:31] == 3'b000) || (dotpSum[33:31] == 3'b111)) begin
         dotpResult = dotpSum[31:0];
      end else if (dotpSum[33]) begin
         dotpResult = 32'h8000_0000;
      end else begin
         dotpResult = 32'h7FFF_FFFF;
      end
   end
`else
   // Wrapping build: the low 32 bits of the 34-bit sum equal a plain
   // modulo-2^32 sum, so the upper bits are never formed.
   always_comb begin
      dotpResult = sOpC_q + $unsigned(prodLo) + $unsigned(prodHi);
   end
`endif

   // Result selection; address post-increment wraps modulo 2^32.
   always_comb begin
      memResult = sOpA_q + 32'(ADDR_INC);
      result    = sIsMem ? memResult : dotpResult;
   end

   // Next state of S. Loading always starts a fresh memory op; leaving S
   // (advance or kill) forgets any remembered handshake; a handshake while
   // writeback stalls is remembered so no second request is issued.
   always_comb begin
      sValid_d  = sValid_q;
      sInstr_d  = sInstr_q;
      sId_d     = sId_q;
      sRd_d     = sRd_q;
      sRs1_d    = sRs1_q;
      sOpA_d    = sOpA_q;
      sOpB_d    = sOpB_q;
      sOpC_d    = sOpC_q;
      memDone_d = memDone_q;
      if (load) begin
         sValid_d  = 1'b1;
         sInstr_d  = id2ex_instr_i;
         sId_d     = id2ex_id_i;
         sRd_d     = id2ex_rd_i;
         sRs1_d    = id2ex_rs1_i;
         sOpA_d    = id2ex_op_a_i;
         sOpB_d    = id2ex_op_b_i;
         sOpC_d    = id2ex_op_c_i;
         memDone_d = 1'b0;
      end else if (advance || sKilled) begin
         sValid_d  = 1'b0;
         memDone_d = 1'b0;
      end else if (memHandshake) begin
         memDone_d = 1'b1;
      end
   end

   // Next state of the writeback bundle. It only changes when writeback is
   // ready; with nothing advancing, only instr drops to INSTR_INVALID.
   always_comb begin
      ex2wbInstr_d  = ex2wbInstr_q;
      ex2wbId_d     = ex2wbId_q;
      ex2wbRd_d     = ex2wbRd_q;
      ex2wbRs1_d    = ex2wbRs1_q;
      ex2wbResult_d = ex2wbResult_q;
      if (advance) begin
         ex2wbInstr_d  = sInstr_q;
         ex2wbId_d     = sId_q;
         ex2wbRd_d     = sRd_q;
         ex2wbRs1_d    = sRs1_q;
         ex2wbResult_d = result;
      end else if (wb_ready_i) begin
         ex2wbInstr_d  = INSTR_INVALID;
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sValid_q      <= 1'b0;
         sInstr_q      <= INSTR_INVALID;
         sId_q         <= '0;
         sRd_q         <= '0;
         sRs1_q        <= '0;
         sOpA_q        <= '0;
         sOpB_q        <= '0;
         sOpC_q        <= '0;
         memDone_q     <= 1'b0;
         ex2wbInstr_q  <= INSTR_INVALID;
         ex2wbId_q     <= '0;
         ex2wbRd_q     <= '0;
         ex2wbRs1_q    <= '0;
         ex2wbResult_q <= '0;
      end else begin
         sValid_q      <= sValid_d;
         sInstr_q      <= sInstr_d;
         sId_q         <= sId_d;
         sRd_q         <= sRd_d;
         sRs1_q        <= sRs1_d;
         sOpA_q        <= sOpA_d;
         sOpB_q        <= sOpB_d;
         sOpC_q        <= sOpC_d;
         memDone_q     <= memDone_d;
         ex2wbInstr_q  <= ex2wbInstr_d;
         ex2wbId_q     <= ex2wbId_d;
         ex2wbRd_q     <= ex2wbRd_d;
         ex2wbRs1_q    <= ex2wbRs1_d;
         ex2wbResult_q <= ex2wbResult_d;
      end
   end

   // Outputs. Request fields come straight from S, so they stay stable for
   // as long as the request is held.
   assign ready_o             = ready;
   assign xif_mem_valid_o     = memValid;
   assign xif_mem_req_id_o    = sId_q;
   assign xif_mem_req_addr_o  = sOpA_q;
   assign xif_mem_req_we_o    = (sInstr_q == INSTR_SW);
   assign xif_mem_req_be_o    = 4'hF;
   assign xif_mem_req_size_o  = 3'b010;
   assign xif_mem_req_wdata_o = (sInstr_q == INSTR_SW) ? sOpB_q : 32'h0;
   assign ex2wb_instr_o       = ex2wbInstr_q;
   assign ex2wb_id_o          = ex2wbId_q;
   assign ex2wb_rd_o          = ex2wbRd_q;
   assign ex2wb_rs1_o         = ex2wbRs1_q;
   assign ex2wb_result_o      = ex2wbResult_q;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// ---------------------------------------------------------------------------
// tb_fir_xifu_ex
//
// Directed bench for fir_xifu_ex: a table of back-to-back XFIRDOTP vectors
// with hand-computed results, followed by hand-written sequences for the
// multi-cycle memory, stall, kill and reset cases.
// ---------------------------------------------------------------------------
module tb_fir_xifu_ex;

   localparam logic [2:0] INSTR_INVALID = 3'd0;
   localparam logic [2:0] INSTR_LW      = 3'd1;
   localparam logic [2:0] INSTR_SW      = 3'd2;
   localparam logic [2:0] INSTR_DOTP    = 3'd3;
   localparam int         NUM_VECS      = 6;

   typedef struct {
      logic [2:0]  instr;
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [31:0] opA;
      logic [31:0] opB;
      logic [31:0] opC;
      logic [31:0] expResult;
   } vec_t;

   logic        clk_i;
   logic        rst_ni;
   logic        id2ex_valid_i;
   logic [2:0]  id2ex_instr_i;
   logic [3:0]  id2ex_id_i;
   logic [4:0]  id2ex_rd_i;
   logic [4:0]  id2ex_rs1_i;
   logic [31:0] id2ex_op_a_i;
   logic [31:0] id2ex_op_b_i;
   logic [31:0] id2ex_op_c_i;
   logic        ready_o;
   logic        xif_mem_valid_o;
   logic        xif_mem_ready_i;
   logic [3:0]  xif_mem_req_id_o;
   logic [31:0] xif_mem_req_addr_o;
   logic        xif_mem_req_we_o;
   logic [3:0]  xif_mem_req_be_o;
   logic [2:0]  xif_mem_req_size_o;
   logic [31:0] xif_mem_req_wdata_o;
   logic [2:0]  ex2wb_instr_o;
   logic [3:0]  ex2wb_id_o;
   logic [4:0]  ex2wb_rd_o;
   logic [4:0]  ex2wb_rs1_o;
   logic [31:0] ex2wb_result_o;
   logic        wb_ready_i;
   logic [15:0] kill_i;

   int          testsRun;
   int          testsFailed;
   int          hsCount;
   int          hsBase;
   vec_t        vecs [NUM_VECS];
   vec_t        tmp;

   fir_xifu_ex #(
      .X_ID_WIDTH (4),
      .ADDR_INC   (4)
   ) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .id2ex_valid_i       (id2ex_valid_i),
      .id2ex_instr_i       (id2ex_instr_i),
      .id2ex_id_i          (id2ex_id_i),
      .id2ex_rd_i          (id2ex_rd_i),
      .id2ex_rs1_i         (id2ex_rs1_i),
      .id2ex_op_a_i        (id2ex_op_a_i),
      .id2ex_op_b_i        (id2ex_op_b_i),
      .id2ex_op_c_i        (id2ex_op_c_i),
      .ready_o             (ready_o),
      .xif_mem_valid_o     (xif_mem_valid_o),
      .xif_mem_ready_i     (xif_mem_ready_i),
      .xif_mem_req_id_o    (xif_mem_req_id_o),
      .xif_mem_req_addr_o  (xif_mem_req_addr_o),
      .xif_mem_req_we_o    (xif_mem_req_we_o),
      .xif_mem_req_be_o    (xif_mem_req_be_o),
      .xif_mem_req_size_o  (xif_mem_req_size_o),
      .xif_mem_req_wdata_o (xif_mem_req_wdata_o),
      .ex2wb_instr_o       (ex2wb_instr_o),
      .ex2wb_id_o          (ex2wb_id_o),
      .ex2wb_rd_o          (ex2wb_rd_o),
      .ex2wb_rs1_o         (ex2wb_rs1_o),
      .ex2wb_result_o      (ex2wb_result_o),
      .wb_ready_i          (wb_ready_i),
      .kill_i              (kill_i)
   );

   // 10-unit clock
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Count completed memory transactions mid-cycle, where both sides are
   // stable.
   initial hsCount = 0;
   always @(negedge clk_i) begin
      if (rst_ni && xif_mem_valid_o && xif_mem_ready_i) hsCount++;
   end

   function automatic vec_t mkVec(input logic [2:0] instr, input logic [3:0] id,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [31:0] opA, input logic [31:0] opB,
                                  input logic [31:0] opC, input logic [31:0] expResult);
      vec_t v;
      v.instr     = instr;
      v.id        = id;
      v.rd        = rd;
      v.rs1       = rs1;
      v.opA       = opA;
      v.opB       = opB;
      v.opC       = opC;
      v.expResult = expResult;
      return v;
   endfunction

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   // Present one instruction on id2ex
   task automatic applyStimulus(input vec_t v);
      id2ex_valid_i = 1'b1;
      id2ex_instr_i = v.instr;
      id2ex_id_i    = v.id;
      id2ex_rd_i    = v.rd;
      id2ex_rs1_i   = v.rs1;
      id2ex_op_a_i  = v.opA;
      id2ex_op_b_i  = v.opB;
      id2ex_op_c_i  = v.opC;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   initial begin
      testsRun      = 0;
      testsFailed   = 0;
      hsBase        = 0;
      rst_ni        = 1'b0;
      id2ex_valid_i = 1'b0;
      id2ex_instr_i = INSTR_INVALID;
      id2ex_id_i    = '0;
      id2ex_rd_i    = '0;
      id2ex_rs1_i   = '0;
      id2ex_op_a_i  = '0;
      id2ex_op_b_i  = '0;
      id2ex_op_c_i  = '0;
      xif_mem_ready_i = 1'b0;
      wb_ready_i    = 1'b1;
      kill_i        = '0;

      // Dot-product vectors: c + lo(a)*lo(b) + hi(a)*hi(b)
      vecs[0] = mkVec(INSTR_DOTP, 4'd1, 5'd10, 5'd11, 32'h0002_0003, 32'h0004_0005, 32'd10, 32'd33);
      vecs[1] = mkVec(INSTR_DOTP, 4'd2, 5'd12, 5'd13, 32'hFFFF_0002, 32'h0003_0004, 32'd0, 32'd5);
      vecs[2] = mkVec(INSTR_DOTP, 4'd3, 5'd14, 5'd15, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'd0, 32'h7FFE_0002);
`ifdef FIR_XIFU_DOTP_SAT_EN
      vecs[3] = mkVec(INSTR_DOTP, 4'd4, 5'd16, 5'd17, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      vecs[4] = mkVec(INSTR_DOTP, 4'd5, 5'd18, 5'd19, 32'h8000_0001, 32'h7FFF_0001, 32'h8000_0000, 32'h8000_0000);
`else
      vecs[3] = mkVec(INSTR_DOTP, 4'd4, 5'd16, 5'd17, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      vecs[4] = mkVec(INSTR_DOTP, 4'd5, 5'd18, 5'd19, 32'h8000_0001, 32'h7FFF_0001, 32'h8000_0000, 32'h4000_8001);
`endif
      vecs[5] = mkVec(INSTR_DOTP, 4'd6, 5'd20, 5'd21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0);

      // Reset state
      #3;
      checkOutput("reset ready_o", 32'(ready_o), 32'd1);
      checkOutput("reset mem_valid", 32'(xif_mem_valid_o), 32'd0);
      checkOutput("reset ex2wb instr", 32'(ex2wb_instr_o), 32'(INSTR_INVALID));
      checkOutput("reset ex2wb result", ex2wb_result_o, 32'd0);
      #9 rst_ni = 1'b1;
      step();

      // Back-to-back dot products, one per cycle
      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("dotp[%0d] ready_o", i), 32'(ready_o), 32'd1);
         step();
         if (i > 0) begin
            checkOutput($sformatf("dotp[%0d] result", i - 1), ex2wb_result_o, vecs[i - 1].expResult);
            checkOutput($sformatf("dotp[%0d] rd", i - 1), 32'(ex2wb_rd_o), 32'(vecs[i - 1].rd));
            checkOutput($sformatf("dotp[%0d] instr", i - 1), 32'(ex2wb_instr_o), 32'(INSTR_DOTP));
         end
      end
      id2ex_valid_i = 1'b0;
      step();
      checkOutput("dotp last result", ex2wb_result_o, vecs[NUM_VECS - 1].expResult);
      checkOutput("dotp last id", 32'(ex2wb_id_o), 32'(vecs[NUM_VECS - 1].id));
      step();
      checkOutput("dotp bubble instr", 32'(ex2wb_instr_o), 32'(INSTR_INVALID));

      // XFIRLW with mem_ready delayed three cycles
      hsBase = hsCount;
      tmp = mkVec(INSTR_LW, 4'd5, 5'd7, 5'd9, 32'h0000_1000, 32'h1234_5678, 32'd0, 32'h0000_1004);
      applyStimulus(tmp);
      step();
      id2ex_valid_i = 1'b0;
      #1;
      checkOutput("lw mem_valid", 32'(xif_mem_valid_o), 32'd1);
      checkOutput("lw addr", xif_mem_req_addr_o, 32'h0000_1000);
      checkOutput("lw we", 32'(xif_mem_req_we_o), 32'd0);
      checkOutput("lw wdata", xif_mem_req_wdata_o, 32'd0);
      checkOutput("lw id", 32'(xif_mem_req_id_o), 32'd5);
      checkOutput("lw be", 32'(xif_mem_req_be_o), 32'hF);
      checkOutput("lw size", 32'(xif_mem_req_size_o), 32'd2);
      checkOutput("lw ready_o waiting", 32'(ready_o), 32'd0);
      for (int c = 0; c < 2; c++) begin
         step();
         #1;
         checkOutput($sformatf("lw held mem_valid %0d", c), 32'(xif_mem_valid_o), 32'd1);
         checkOutput($sformatf("lw held addr %0d", c), xif_mem_req_addr_o, 32'h0000_1000);
      end
      step();
      xif_mem_ready_i = 1'b1;
      #1;
      checkOutput("lw ready_o on handshake", 32'(ready_o), 32'd1);
      step();
      xif_mem_ready_i = 1'b0;
      #1;
      checkOutput("lw result", ex2wb_result_o, 32'h0000_1004);
      checkOutput("lw rd", 32'(ex2wb_rd_o), 32'd7);
      checkOutput("lw rs1", 32'(ex2wb_rs1_o), 32'd9);
      checkOutput("lw instr", 32'(ex2wb_instr_o), 32'(INSTR_LW));
      checkOutput("lw mem_valid after", 32'(xif_mem_valid_o), 32'd0);
      checkOutput("lw transactions", 32'(hsCount - hsBase), 32'd1);

      // XFIRSW with immediate mem_ready and writeback stalled two cycles
      wb_ready_i = 1'b0;
      xif_mem_ready_i = 1'b1;
      hsBase = hsCount;
      tmp = mkVec(INSTR_SW, 4'd2, 5'd1, 5'd3, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'd0, 32'd0);
      applyStimulus(tmp);
      step();
      id2ex_valid_i = 1'b0;
      #1;
      checkOutput("sw mem_valid", 32'(xif_mem_valid_o), 32'd1);
      checkOutput("sw we", 32'(xif_mem_req_we_o), 32'd1);
      checkOutput("sw wdata", xif_mem_req_wdata_o, 32'hDEAD_BEEF);
      checkOutput("sw addr", xif_mem_req_addr_o, 32'hFFFF_FFFC);
      checkOutput("sw ready_o stall 1", 32'(ready_o), 32'd0);
      step();
      #1;
      checkOutput("sw no second request", 32'(xif_mem_valid_o), 32'd0);
      checkOutput("sw ready_o stall 2", 32'(ready_o), 32'd0);
      checkOutput("sw ex2wb held", 32'(ex2wb_instr_o), 32'(INSTR_LW));
      step();
      wb_ready_i = 1'b1;
      #1;
      checkOutput("sw ready_o released", 32'(ready_o), 32'd1);
      step();
      xif_mem_ready_i = 1'b0;
      #1;
      checkOutput("sw result wrap", ex2wb_result_o, 32'h0000_0000);
      checkOutput("sw instr", 32'(ex2wb_instr_o), 32'(INSTR_SW));
      checkOutput("sw rd", 32'(ex2wb_rd_o), 32'd1);
      checkOutput("sw transactions", 32'(hsCount - hsBase), 32'd1);
      step();

      // Kill of a waiting XFIRLW, id 3
      tmp = mkVec(INSTR_LW, 4'd3, 5'd4, 5'd6, 32'h0000_2000, 32'd0, 32'd0, 32'h0000_2004);
      applyStimulus(tmp);
      step();
      id2ex_valid_i = 1'b0;
      #1;
      checkOutput("kill pre mem_valid", 32'(xif_mem_valid_o), 32'd1);
      kill_i = 16'h0010;
      #1;
      checkOutput("kill other id no effect", 32'(xif_mem_valid_o), 32'd1);
      step();
      kill_i = 16'h0008;
      xif_mem_ready_i = 1'b1;
      hsBase = hsCount;
      #1;
      checkOutput("kill mem_valid gated", 32'(xif_mem_valid_o), 32'd0);
      checkOutput("kill ready_o", 32'(ready_o), 32'd1);
      step();
      kill_i = '0;
      xif_mem_ready_i = 1'b0;
      #1;
      checkOutput("kill no transaction", 32'(hsCount - hsBase), 32'd0);
      checkOutput("kill mem_valid after", 32'(xif_mem_valid_o), 32'd0);
      checkOutput("kill ex2wb instr", 32'(ex2wb_instr_o), 32'(INSTR_INVALID));
      checkOutput("kill ex2wb result", ex2wb_result_o, 32'h0000_0000);
      applyStimulus(vecs[0]);
      #1;
      checkOutput("kill next accept", 32'(ready_o), 32'd1);
      step();
      id2ex_valid_i = 1'b0;
      step();
      checkOutput("kill next result", ex2wb_result_o, 32'd33);

      // Reset in the middle of a memory request
      tmp = mkVec(INSTR_LW, 4'd6, 5'd2, 5'd8, 32'h0000_3000, 32'd0, 32'd0, 32'h0000_3004);
      applyStimulus(tmp);
      step();
      id2ex_valid_i = 1'b0;
      #1;
      checkOutput("rst pre mem_valid", 32'(xif_mem_valid_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      checkOutput("rst mem_valid async", 32'(xif_mem_valid_o), 32'd0);
      checkOutput("rst ready_o", 32'(ready_o), 32'd1);
      checkOutput("rst ex2wb instr", 32'(ex2wb_instr_o), 32'(INSTR_INVALID));
      step();
      rst_ni = 1'b1;
      step();
      #1;
      checkOutput("rst S discarded", 32'(xif_mem_valid_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
